fatori_mon_err_collector: RTL and testbench
===========================================

// Module: fatori_mon_err_collector
// PURPOSE
//  Consumer end of the FATORI monitor error interface. Samples the min_err/maj_err/scrub_occurred
//  lines of K monitored wrappers (voters, wrapped sub-blocks) and detects rising edges.
//  Keeps saturating per-source/per-kind counters and queues timestamped events in a FIFO.
//  Events drain through a valid/ready port. Sits at core top level beside the FI/debug logic.
// PARAMETERS
//  K          4   number of monitored sources (>=1)
//  CNT_W      16  width of each event counter
//  TS_W       16  width of free-running timestamp
//  FIFO_DEPTH 8   event FIFO entries (power of 2, >=2)
// PORTS
//  clk_i       in   1               clock
//  rst_i       in   1               synchronous, active-high reset
//  min_err_i   in   K               per-source minority-error level
//  maj_err_i   in   K               per-source majority-error level
//  scrub_i     in   K               per-source scrub-occurred level
//  clr_i       in   1               clear counters and sticky flags
//  evt_valid_o out  1               FIFO head valid
//  evt_ready_i in   1               consumer accepts head
//  evt_src_o   out  $clog2(K)(min1) head source index
//  evt_kind_o  out  2               head kind: 00 scrub, 01 min, 10 maj
//  evt_ts_o    out  TS_W            timestamp captured at enqueue
//  cnt_src_i   in   $clog2(K)(min1) counter read source select
//  cnt_kind_i  in   2               counter read kind select (11 reads 0)
//  cnt_o       out  CNT_W           selected counter, combinational read of registers
//  any_maj_o   out  1               sticky: any maj event since reset/clr
//  coalesce_o  out  1               sticky: edge merged into an already-pending event
// BEHAVIOUR
//  - Reset, checked at the clock edge: all outputs 0. Clears prev-sample regs, pending bits,
//    counters, timestamp, FIFO pointers and sticky flags.
//  - Edge detect: each input has a registered previous sample. Event (s,k) fires in cycle t
//    when in[s]=1 and prev[s]=0. A level held high (voter HOLD=1) yields exactly one event.
//  - Counters: on an event, cnt[s][k] += 1, saturating at 2^CNT_W-1 (no wrap).
//    The update is visible on cnt_o at t+1.
//  - Pending: 3K bits. An event sets pending[s][k] at the end of t.
//    If pending[s][k] is already 1 and not being dequeued that cycle: the bit stays 1,
//    the counter still increments, and coalesce_o is set.
//  - Arbiter (combinational from pending): fixed priority. maj over min over scrub; within a
//    kind, lowest s wins. A winner is pushed when the FIFO is not full; its pending bit clears
//    in the same cycle. One push per cycle max. No push when full (pending holds; nothing lost).
//  - Timestamp: TS_W counter, +1 every cycle, wraps to 0. Value written with the entry = ts at push.
//  - Latency: edge sampled in cycle t -> push in t+1 -> evt_valid_o=1 in t+2 if the FIFO was empty.
//  - FIFO: pop when evt_valid_o && evt_ready_i. Push and pop in the same cycle are allowed
//    when not full. When full, push is blocked even if pop occurs that cycle.
//    Head outputs are stable while valid and not popped.
//    Pointers are log2(DEPTH)+1 bits: full = MSBs differ, lower bits equal.
//  - clr_i: synchronously zeroes counters, any_maj_o and coalesce_o. It has priority over a
//    same-cycle increment, so the counter reads 0 afterwards. That event is still marked pending
//    and queued. A maj event in the clr cycle does not set any_maj_o.
//    FIFO, pending bits and timestamp are unaffected.
//  - any_maj_o is set at the end of any cycle with a maj event (absent clr).
//  - Reset mid-operation drops all queued and pending events. Inputs already high at reset
//    release produce no event until they fall and rise again: prev regs are reset to 0, but
//    edge detection is suppressed in the first cycle after reset.
// TESTING
//  1. Single pulse: min_err_i[2] 0->1 at cycle 10, held high -> one event {src=2,kind=01}
//     valid at cycle 12; cnt(2,01)=1; no second event.
//  2. Simultaneous: cycle 20 maj_err_i[3], min_err_i[0], scrub_i[1] rise together ->
//     pop order maj/3, min/0, scrub/1; ts strictly +1 per entry with ready held 1.
//  3. Backpressure: ready=0, 12 distinct events -> 8 queued, 4 held pending.
//     Re-edge of a pending one sets coalesce_o. After draining: 12 entries out, counter total 13.
//  4. Saturation: CNT_W=4, 20 edges on scrub_i[0] -> cnt stays 15.
//  5. clr_i in the same cycle as a maj edge -> counters 0, any_maj_o=0, event still popped.
//     Next maj edge -> any_maj_o=1.
//  6. rst_i asserted with 5 entries queued -> evt_valid_o=0 the next cycle, all counters 0.
//     Held-high inputs create no event after reset.

Source files
------------

// File: rtl/fatori_mon_err_collector.sv
// fatori_mon_err_collector
// Consumer end of the FATORI monitor error interface. Detects rising edges on the
// min/maj/scrub lines of K wrappers, keeps saturating per-source/per-kind counters,
// and queues timestamped events (one per cycle, fixed priority) into a small FIFO
// that drains through a valid/ready port.
// Kind encoding used throughout: 0 = scrub, 1 = min, 2 = maj.

module fatori_mon_err_collector #(
   parameter  int K          = 4,
   parameter  int CNT_W      = 16,
   parameter  int TS_W       = 16,
   parameter  int FIFO_DEPTH = 8,
   localparam int SRC_W      = (K > 1) ? $clog2(K) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [K-1:0]     min_err_i,
   input  logic [K-1:0]     maj_err_i,
   input  logic [K-1:0]     scrub_i,
   input  logic             clr_i,
   output logic             evt_valid_o,
   input  logic             evt_ready_i,
   output logic [SRC_W-1:0] evt_src_o,
   output logic [1:0]       evt_kind_o,
   output logic [TS_W-1:0]  evt_ts_o,
   input  logic [SRC_W-1:0] cnt_src_i,
   input  logic [1:0]       cnt_kind_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             any_maj_o,
   output logic             coalesce_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [2:0][K-1:0] lvl_s;
   logic [2:0][K-1:0] prev_r;
   logic [2:0][K-1:0] evt_s;
   logic [2:0][K-1:0] pend_r;
   logic [2:0][K-1:0] grant_s;
   logic              supp_r;

   logic [CNT_W-1:0]  cnt_r [3][K];

   logic              gnt_vld_s;
   logic [1:0]        gnt_kind_s;
   logic [SRC_W-1:0]  gnt_src_s;
   logic              push_s;
   logic              pop_s;
   logic              full_s;
   logic              empty_s;
   logic              coal_evt_s;

   logic [AW:0]       wr_ptr_r;
   logic [AW:0]       rd_ptr_r;
   logic [SRC_W-1:0]  src_mem_r  [FIFO_DEPTH];
   logic [1:0]        kind_mem_r [FIFO_DEPTH];
   logic [TS_W-1:0]   ts_mem_r   [FIFO_DEPTH];

   logic [TS_W-1:0]   ts_r;
   logic              any_maj_r;
   logic              coal_r;

   assign lvl_s = {maj_err_i, min_err_i, scrub_i};

   // Rising-edge detect; masked for one cycle after reset so held-high lines stay silent
   always_comb begin
      evt_s = lvl_s & ~prev_r & {(3*K){~supp_r}};
   end

   // Previous-sample registers and post-reset edge suppression flag
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_r <= '0;
         supp_r <= 1'b1;
      end else begin
         prev_r <= lvl_s;
         supp_r <= 1'b0;
      end
   end

   // FIFO occupancy flags derived from the extended pointers
   always_comb begin
      empty_s = (wr_ptr_r == rd_ptr_r);
      full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
      pop_s   = !empty_s && evt_ready_i;
   end

   // Fixed-priority arbiter: maj over min over scrub, lowest source first within a kind
   always_comb begin
      gnt_vld_s  = 1'b0;
      gnt_kind_s = 2'd0;
      gnt_src_s  = '0;
      for (int k = 2; k >= 0; k--) begin
         for (int s = 0; s < K; s++) begin
            if (pend_r[k][s] && !gnt_vld_s) begin
               gnt_vld_s  = 1'b1;
               gnt_kind_s = 2'(k);
               gnt_src_s  = SRC_W'(s);
            end else begin
               gnt_vld_s  = gnt_vld_s;
            end
         end
      end
      push_s  = gnt_vld_s && !full_s;
      grant_s = '0;
      if (push_s) begin
         grant_s[gnt_kind_s][gnt_src_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
      coal_evt_s = |(evt_s & pend_r & ~grant_s);
   end

   // Pending bits: the pushed winner clears, new edges set (re-arming a bit pushed this cycle)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_r <= '0;
      end else begin
         pend_r <= (pend_r & ~grant_s) | evt_s;
      end
   end

   // Saturating event counters; clear wins over a same-cycle increment
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < 3; k++) begin
         for (int s = 0; s < K; s++) begin
            if (rst_i || clr_i) begin
               cnt_r[k][s] <= '0;
            end else if (evt_s[k][s] && (cnt_r[k][s] != {CNT_W{1'b1}})) begin
               cnt_r[k][s] <= cnt_r[k][s] + CNT_W'(1);
            end else begin
               cnt_r[k][s] <= cnt_r[k][s];
            end
         end
      end
   end

   // Free-running timestamp, wraps naturally
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ts_r <= '0;
      end else begin
         ts_r <= ts_r + TS_W'(1);
      end
   end

   // FIFO pointers; reset drops every queued entry
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         wr_ptr_r <= push_s ? wr_ptr_r + (AW+1)'(1) : wr_ptr_r;
         rd_ptr_r <= pop_s  ? rd_ptr_r + (AW+1)'(1) : rd_ptr_r;
      end
   end

   // FIFO storage; contents are only observable through valid-gated head outputs
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         src_mem_r[wr_ptr_r[AW-1:0]]  <= gnt_src_s;
         kind_mem_r[wr_ptr_r[AW-1:0]] <= gnt_kind_s;
         ts_mem_r[wr_ptr_r[AW-1:0]]   <= ts_r;
      end else begin
         src_mem_r[wr_ptr_r[AW-1:0]]  <= src_mem_r[wr_ptr_r[AW-1:0]];
      end
   end

   // Sticky flags: any maj event, and edges merged into already-pending events
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         any_maj_r <= 1'b0;
         coal_r    <= 1'b0;
      end else begin
         any_maj_r <= any_maj_r | (|evt_s[2]);
         coal_r    <= coal_r | coal_evt_s;
      end
   end

   // Head outputs, forced to zero while the FIFO is empty
   always_comb begin
      evt_valid_o = !empty_s;
      if (!empty_s) begin
         evt_src_o  = src_mem_r[rd_ptr_r[AW-1:0]];
         evt_kind_o = kind_mem_r[rd_ptr_r[AW-1:0]];
         evt_ts_o   = ts_mem_r[rd_ptr_r[AW-1:0]];
      end else begin
         evt_src_o  = '0;
         evt_kind_o = 2'd0;
         evt_ts_o   = '0;
      end
   end

   // Counter read mux; kind 3 or an out-of-range source reads zero
   always_comb begin
      cnt_o = '0;
      if (int'(cnt_src_i) < K) begin
         case (cnt_kind_i)
            2'd0:    cnt_o = cnt_r[0][cnt_src_i];
            2'd1:    cnt_o = cnt_r[1][cnt_src_i];
            2'd2:    cnt_o = cnt_r[2][cnt_src_i];
            default: cnt_o = '0;
         endcase
      end else begin
         cnt_o = '0;
      end
   end

   assign any_maj_o  = any_maj_r;
   assign coalesce_o = coal_r;

endmodule

// File: tb/tb_fatori_mon_err_collector.sv
// Randomized bench for fatori_mon_err_collector with an event-queue reference model.
// Small counter and timestamp widths expose counter saturation and timestamp wrap.

module tb_fatori_mon_err_collector;

   localparam int K     = 4;
   localparam int CNT_W = 4;
   localparam int TS_W  = 8;
   localparam int DEPTH = 8;
   localparam int SRC_W = 2;
   localparam int NCYC  = 6000;

   logic             clk = 1'b0;
   logic             rst;
   logic [K-1:0]     min_err, maj_err, scrub;
   logic             clr;
   logic             evt_valid;
   logic             evt_ready;
   logic [SRC_W-1:0] evt_src;
   logic [1:0]       evt_kind;
   logic [TS_W-1:0]  evt_ts;
   logic [SRC_W-1:0] cnt_src;
   logic [1:0]       cnt_kind;
   logic [CNT_W-1:0] cnt;
   logic             any_maj;
   logic             coalesce;

   fatori_mon_err_collector #(
      .K(K), .CNT_W(CNT_W), .TS_W(TS_W), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .min_err_i(min_err), .maj_err_i(maj_err), .scrub_i(scrub),
      .clr_i(clr),
      .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
      .evt_src_o(evt_src), .evt_kind_o(evt_kind), .evt_ts_o(evt_ts),
      .cnt_src_i(cnt_src), .cnt_kind_i(cnt_kind), .cnt_o(cnt),
      .any_maj_o(any_maj), .coalesce_o(coalesce)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int src; int kind; int ts; } ev_t;
   ev_t m_q[$];
   bit  m_pend [3][K];
   bit  m_prev [3][K];
   int  m_cnt  [3][K];
   bit  m_fresh;      // first cycle after reset: edges ignored
   bit  m_any_maj;
   bit  m_coal;
   int  m_ts;
   int  n_popped = 0;

   function automatic bit level(int k, int s);
      case (k)
         0:       return scrub[s];
         1:       return min_err[s];
         default: return maj_err[s];
      endcase
   endfunction

   task automatic model_reset();
      m_q.delete();
      for (int k = 0; k < 3; k++)
         for (int s = 0; s < K; s++) begin
            m_pend[k][s] = 0; m_prev[k][s] = 0; m_cnt[k][s] = 0;
         end
      m_fresh = 1; m_any_maj = 0; m_coal = 0; m_ts = 0;
   endtask

   // Effect of one clock edge given the inputs currently applied
   task automatic model_step();
      int  gk, gs;
      bit  room, pop, merged, maj_seen;
      if (rst) begin
         model_reset();
         return;
      end
      room = (m_q.size() < DEPTH);
      pop  = (m_q.size() > 0) && evt_ready;
      gk = -1; gs = -1;
      if (room) begin
         for (int k = 2; k >= 0 && gk < 0; k--)
            for (int s = 0; s < K && gk < 0; s++)
               if (m_pend[k][s]) begin gk = k; gs = s; end
      end
      if (gk >= 0) m_pend[gk][gs] = 0;
      merged = 0; maj_seen = 0;
      for (int k = 0; k < 3; k++)
         for (int s = 0; s < K; s++) begin
            if (!m_fresh && level(k, s) && !m_prev[k][s]) begin
               if (m_pend[k][s]) merged = 1;
               m_pend[k][s] = 1;
               if (m_cnt[k][s] < (1 << CNT_W) - 1) m_cnt[k][s]++;
               if (k == 2) maj_seen = 1;
            end
            m_prev[k][s] = level(k, s);
         end
      if (clr) begin
         for (int k = 0; k < 3; k++)
            for (int s = 0; s < K; s++) m_cnt[k][s] = 0;
         m_any_maj = 0; m_coal = 0;
      end else begin
         m_any_maj |= maj_seen;
         m_coal    |= merged;
      end
      if (pop) begin void'(m_q.pop_front()); n_popped++; end
      if (gk >= 0) m_q.push_back('{src: gs, kind: gk, ts: m_ts});
      m_fresh = 0;
      m_ts = (m_ts + 1) % (1 << TS_W);
   endtask

   task automatic check_outputs();
      int exp_cnt;
      check_val("evt_valid", evt_valid, (m_q.size() != 0));
      if (m_q.size() != 0) begin
         check_val("evt_src",  evt_src,  m_q[0].src);
         check_val("evt_kind", evt_kind, m_q[0].kind);
         check_val("evt_ts",   evt_ts,   m_q[0].ts);
      end
      exp_cnt = (cnt_kind == 2'd3) ? 0 : m_cnt[cnt_kind][cnt_src];
      check_val("cnt", cnt, exp_cnt);
      check_val("any_maj", any_maj, m_any_maj);
      check_val("coalesce", coalesce, m_coal);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int ready_pct;
      rst = 1'b1; clr = 1'b0; evt_ready = 1'b0;
      min_err = '0; maj_err = '0; scrub = '0;
      cnt_src = '0; cnt_kind = 2'd0;
      model_reset();
      @(negedge clk);
      // Reset state
      #1;
      check_outputs();
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         case ((cyc / 400) % 4)
            0:       ready_pct = 10;
            1:       ready_pct = 50;
            2:       ready_pct = 100;
            default: ready_pct = 0;
         endcase
         rst = ($urandom_range(699) == 0);
         clr = ($urandom_range(199) == 0);
         evt_ready = ($urandom_range(99) < ready_pct);
         for (int s = 0; s < K; s++) begin
            if ($urandom_range(7) == 0) min_err[s] = ~min_err[s];
            if ($urandom_range(9) == 0) maj_err[s] = ~maj_err[s];
            if ($urandom_range(7) == 0) scrub[s]   = ~scrub[s];
         end
         cnt_src  = SRC_W'($urandom_range(K - 1));
         cnt_kind = 2'($urandom_range(3));
         #1;
         check_outputs();
         model_step();
      end
      if (n_popped == 0) check_val("events_popped", 32'd0, 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
